cordic_descale: RTL and testbench

//  Inverse CORDIC gain compensation: multiplies a signed Q4.8 sample by 1/K ~= 0.6072529 (K = 10-iteration gain).

---
 rtl/cordic_descale_if.sv | 52 +++++
 rtl/cordic_descale.sv | 131 +++++++++++++
 tb/tb_cordic_descale.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_descale_if.sv
// -----------------------------------------------------------------------------
// cordic_descale_if
//   Groups the input and output valid/ready channels of cordic_descale.
//
//   Signals:
//     in_valid   producer -> block   input sample present
//     in_ready   block -> producer   block accepts a sample this cycle
//     in_value   producer -> block   signed Q4.8 sample
//     in_id      producer -> block   tag carried with in_value
//     out_valid  block -> consumer   out_value/out_id valid
//     out_ready  consumer -> block   consumer accepts output this cycle
//     out_value  block -> consumer   signed Q4.8 descaled sample
//     out_id     block -> consumer   tag of the sample on out_value
//
//   Modports:
//     master  the environment around the block (drives in_*, out_ready)
//     slave   the block itself (drives in_ready, out_*)
// -----------------------------------------------------------------------------
interface cordic_descale_if #(
  parameter int ID_WIDTH = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [11:0]         in_value;
  logic [ID_WIDTH-1:0] in_id;
  logic                out_valid;
  logic                out_ready;
  logic [11:0]         out_value;
  logic [ID_WIDTH-1:0] out_id;

  modport master (
    output in_valid,
    output in_value,
    output in_id,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_value,
    input  out_id
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  in_id,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_value,
    output out_id
  );
endinterface

// File: rtl/cordic_descale.sv
// -----------------------------------------------------------------------------
// cordic_descale
//   Inverse CORDIC gain compensation. Multiplies a signed Q4.8 sample by
//   approximately 1/K = 0.6072529 using a multiplier-free shift-add pipeline:
//     y = x/2 + x/8 - x/64 - x/512 - x/8192   (effective gain 0.6072998)
//   Seven register stages S0..S6, one sample per cycle, latency 6 edges.
//   The whole pipeline advances together whenever the output register is
//   empty or being drained, so a stalled output freezes every stage.
//
//   Parameters:
//     ID_WIDTH  width of the tag travelling with each sample
//     GUARD     extra fractional bits in the accumulator (must be >= 8)
//
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset, clears all stages
//     bus      cordic_descale_if.slave: in_* / out_* valid-ready channels
//     busy     high while any stage holds a valid sample
//
//   Build option:
//     DESCALE_ROUND_EN  when defined, the output stage rounds half toward
//                       +inf; otherwise it floors (truncates toward -inf).
//                       Latency and handshake are the same in both builds.
// -----------------------------------------------------------------------------
module cordic_descale #(
  parameter int ID_WIDTH = 8,
  parameter int GUARD    = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  cordic_descale_if.slave bus,
  output logic            busy
);

  // Accumulator width: 12-bit sample, GUARD fraction bits, 4 bits headroom.
  localparam int XW    = 12 + GUARD + 4;
  localparam int LAST  = 6;   // index of the output stage
  localparam int NTERM = 5;   // shift-add terms, applied in S1..S5

  logic                  adv;
  logic                  accept;
  logic signed [XW-1:0]  x_in;

  // Per-stage state. x is only needed up to the last term stage's input
  // (S4), acc up to S5; S6 holds only the final value and the tag.
  logic [LAST:0]         valid_reg;
  logic [ID_WIDTH-1:0]   id_reg   [LAST+1];
  logic signed [XW-1:0]  x_reg    [NTERM];
  logic signed [XW-1:0]  acc_reg  [NTERM+1];
  logic [11:0]           value_reg;

  logic signed [XW-1:0]  acc_next [NTERM+1];
  logic [11:0]           value_next;

  // The pipeline moves only as a whole: it may advance when the output
  // register is empty or is being taken this cycle.
  assign adv    = ~valid_reg[LAST] | bus.out_ready;
  assign accept = bus.in_valid & adv;

  // Sign-extend the Q4.8 sample and append GUARD zero fraction bits.
  assign x_in = {{4{bus.in_value[11]}}, bus.in_value, {GUARD{1'b0}}};

  // S0 starts every sample with an empty accumulator.
  assign acc_next[0] = '0;

  // One shift-add term per stage S1..S5. Shifts are arithmetic, so every
  // term floors toward -inf exactly as the reference gain assumes.
  generate
    for (genvar gi = 1; gi <= NTERM; gi++) begin : g_term
      localparam int SH  = (gi == 1) ? 1 :
                           (gi == 2) ? 3 :
                           (gi == 3) ? 6 :
                           (gi == 4) ? 9 : 13;
      localparam bit NEG = (gi >= 3);

      if (NEG) begin : g_sub
        assign acc_next[gi] = acc_reg[gi-1] - (x_reg[gi-1] >>> SH);
      end else begin : g_add
        assign acc_next[gi] = acc_reg[gi-1] + (x_reg[gi-1] >>> SH);
      end
    end
  endgenerate

  // Output stage: drop the guard bits. |1/K| < 1 so the result always fits
  // in 12 bits and the upper bits can simply be discarded.
`ifdef DESCALE_ROUND_EN
  localparam logic signed [XW-1:0] HALF =
    {{(XW-GUARD){1'b0}}, 1'b1, {(GUARD-1){1'b0}}};
  assign value_next = 12'((acc_reg[NTERM] + HALF) >>> GUARD);
`else
  assign value_next = 12'(acc_reg[NTERM] >>> GUARD);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      value_reg <= '0;
      for (int i = 0; i <= LAST; i++) begin
        id_reg[i] <= '0;
      end
      for (int i = 0; i < NTERM; i++) begin
        x_reg[i] <= '0;
      end
      for (int i = 0; i <= NTERM; i++) begin
        acc_reg[i] <= '0;
      end
    end else if (adv) begin
      // Bubbles travel as valid=0; data of invalid stages is don't-care.
      valid_reg <= {valid_reg[LAST-1:0], accept};
      id_reg[0] <= bus.in_id;
      for (int i = 1; i <= LAST; i++) begin
        id_reg[i] <= id_reg[i-1];
      end
      x_reg[0] <= x_in;
      for (int i = 1; i < NTERM; i++) begin
        x_reg[i] <= x_reg[i-1];
      end
      for (int i = 0; i <= NTERM; i++) begin
        acc_reg[i] <= acc_next[i];
      end
      value_reg <= value_next;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_reg[LAST];
  assign bus.out_value = value_reg;
  assign bus.out_id    = id_reg[LAST];
  assign busy          = |valid_reg;

endmodule

// File: tb/tb_cordic_descale.sv
// -----------------------------------------------------------------------------
// tb_cordic_descale
//   Self-checking bench for cordic_descale. Directed vectors with hand-derived
//   results, streaming, stall, mid-flight reset and a random handshake run
//   against a reference shift-add model. Honours DESCALE_ROUND_EN so the same
//   file checks either build.
// -----------------------------------------------------------------------------
module tb_cordic_descale;
  localparam int IDW   = 8;
  localparam int GRD   = 8;

  logic clock;
  logic reset_n;
  logic busy;
  int   checks;
  int   errors;

  cordic_descale_if #(.ID_WIDTH(IDW)) bus ();

  cordic_descale #(
    .ID_WIDTH (IDW),
    .GUARD    (GRD)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-computed directed vectors (Q4.8).
  //   0x100 ( 1.0): acc = 32768+8192-1024-128-8 = 39800 -> 155.47
  //   0x003       : acc = 384+96-12-1-0        = 467   -> 1.82
  //   0xF00 (-1.0): acc = -39800                        -> -155.47
  //   0x200 ( 2.0): acc = 79600                         -> 310.94
  localparam logic [11:0] DIR_IN  [3] = '{12'h100, 12'h003, 12'hF00};
  localparam logic [7:0]  DIR_ID  [3] = '{8'h5A, 8'h21, 8'hC3};
`ifdef DESCALE_ROUND_EN
  localparam logic [11:0] DIR_EXP [3] = '{12'h09B, 12'h002, 12'hF65};
  localparam logic [11:0] TWO_EXP     = 12'h137;
`else
  localparam logic [11:0] DIR_EXP [3] = '{12'h09B, 12'h001, 12'hF64};
  localparam logic [11:0] TWO_EXP     = 12'h136;
`endif

  // Reference: y = x/2 + x/8 - x/64 - x/512 - x/8192 on the guard-extended
  // sample, each term floored, then guard bits dropped.
  function automatic logic [11:0] model(input logic [11:0] v);
    longint x;
    longint acc;
    x   = longint'(signed'(v)) * 256;
    acc = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 13);
`ifdef DESCALE_ROUND_EN
    acc = acc + 128;
`endif
    return 12'(acc >>> 8);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_id     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_value !== 12'h000) begin
      errors++;
      $display("FAIL reset_out_value got %03h want 000", bus.out_value);
    end
    checks++;
    if (bus.out_id !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_id got %02h want 00", bus.out_id);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0b want 0", busy);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  // Sends one sample into an empty pipeline and reports how many edges after
  // the accepting edge the result appeared, plus the result itself.
  task automatic send_one(input logic [11:0] v, input logic [7:0] id,
                          output int lat, output logic [11:0] ov,
                          output logic [7:0] oid);
    bus.out_ready = 1'b1;
    bus.in_value  = v;
    bus.in_id     = id;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    ov  = bus.out_value;
    oid = bus.out_id;
    tick();
  endtask

  task automatic test_directed();
    int          lat;
    logic [11:0] ov;
    logic [7:0]  oid;
    for (int k = 0; k < 3; k++) begin
      send_one(DIR_IN[k], DIR_ID[k], lat, ov, oid);
      $display("directed in=%03h id=%02h -> out=%03h id=%02h latency=%0d",
               DIR_IN[k], DIR_ID[k], ov, oid, lat);
      checks++;
      if (lat != 6) begin
        errors++;
        $display("FAIL directed_latency[%0d] got %0d want 6", k, lat);
      end
      checks++;
      if (ov !== DIR_EXP[k]) begin
        errors++;
        $display("FAIL directed_value[%0d] got %03h want %03h", k, ov, DIR_EXP[k]);
      end
      checks++;
      if (oid !== DIR_ID[k]) begin
        errors++;
        $display("FAIL directed_id[%0d] got %02h want %02h", k, oid, DIR_ID[k]);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_dup[%0d] out_valid got %0b want 0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] q[$];
    logic [19:0] exp_v;
    int sent = 0;
    int got = 0;
    int last_cyc = 0;
    int gaps = 0;
    int ready_low = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.in_valid = (sent < 20);
      bus.in_value = 12'(sent * 173 + 7);
      bus.in_id    = 8'(8'h40 + sent);
      #1;
      if (bus.in_valid) begin
        if (!bus.in_ready) ready_low++;
        else begin
          q.push_back({model(bus.in_value), bus.in_id});
          sent++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected got %03h/%02h want none", bus.out_value, bus.out_id);
        end else begin
          exp_v = q.pop_front();
          if ({bus.out_value, bus.out_id} !== exp_v) begin
            errors++;
            $display("FAIL b2b_out[%0d] got %03h/%02h want %03h/%02h",
                     got, bus.out_value, bus.out_id, exp_v[19:8], exp_v[7:0]);
          end
        end
        if (got > 0 && cyc != last_cyc + 1) gaps++;
        last_cyc = cyc;
        got++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    $display("back_to_back sent=%0d got=%0d", sent, got);
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL b2b_count got %0d want 20", got);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_gaps got %0d want 0", gaps);
    end
    checks++;
    if (ready_low != 0) begin
      errors++;
      $display("FAIL b2b_in_ready_low got %0d want 0", ready_low);
    end
  endtask

  task automatic test_stall();
    logic [19:0] q[$];
    logic [19:0] exp_v;
    logic [11:0] hv;
    logic [7:0]  hi;
    int accepted = 0;
    int got = 0;
    int gaps = 0;
    int last_cyc = 0;
    bit stalled = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && !stalled; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_value = 12'(accepted * 291 + 100);
      bus.in_id    = 8'(8'h80 + accepted);
      #1;
      if (bus.in_ready) begin
        q.push_back({model(bus.in_value), bus.in_id});
        accepted++;
        tick();
      end else begin
        stalled = 1;
      end
    end
    checks++;
    if (accepted != 7) begin
      errors++;
      $display("FAIL stall_fill got %0d want 7", accepted);
    end
    hv = bus.out_value;
    hi = bus.out_id;
    for (int s = 0; s < 5; s++) begin
      tick();
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready[%0d] got %0b want 0", s, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_value !== hv || bus.out_id !== hi) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %0b/%03h/%02h want 1/%03h/%02h",
                 s, bus.out_valid, bus.out_value, bus.out_id, hv, hi);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stall_unexpected got %03h/%02h want none", bus.out_value, bus.out_id);
        end else begin
          exp_v = q.pop_front();
          if ({bus.out_value, bus.out_id} !== exp_v) begin
            errors++;
            $display("FAIL stall_out[%0d] got %03h/%02h want %03h/%02h",
                     got, bus.out_value, bus.out_id, exp_v[19:8], exp_v[7:0]);
          end
        end
        if (got > 0 && cyc != last_cyc + 1) gaps++;
        last_cyc = cyc;
        got++;
      end
      tick();
    end
    $display("stall drained=%0d", got);
    checks++;
    if (got != 7 || gaps != 0) begin
      errors++;
      $display("FAIL stall_drain got %0d outputs %0d gaps want 7 outputs 0 gaps", got, gaps);
    end
  endtask

  task automatic test_reset_midflight();
    int          lat;
    int          stale = 0;
    logic [11:0] ov;
    logic [7:0]  oid;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_value = 12'(12'h050 + k);
      bus.in_id    = 8'(8'hE0 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before got %0b want 1", busy);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear got valid=%0b busy=%0b want 0/0", bus.out_valid, busy);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid || busy) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midreset_stale got %0d cycles want 0", stale);
    end
    send_one(12'h200, 8'h77, lat, ov, oid);
    $display("after_reset in=200 id=77 -> out=%03h id=%02h latency=%0d", ov, oid, lat);
    checks++;
    if (lat != 6 || ov !== TWO_EXP || oid !== 8'h77) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d %03h/%02h want lat=6 %03h/77",
               lat, ov, oid, TWO_EXP);
    end
  endtask

  task automatic test_random();
    logic [19:0] q[$];
    logic [19:0] exp_v;
    logic [19:0] held;
    bit          hold_pending = 0;
    int sent = 0;
    int got = 0;
    int hold_err = 0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      bus.in_valid  = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      bus.in_value  = 12'($urandom);
      bus.in_id     = 8'($urandom);
      bus.out_ready = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (hold_pending && (bus.out_valid !== 1'b1 || {bus.out_value, bus.out_id} !== held))
        hold_err++;
      hold_pending = bus.out_valid && !bus.out_ready;
      held = {bus.out_value, bus.out_id};
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({model(bus.in_value), bus.in_id});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected got %03h/%02h want none", bus.out_value, bus.out_id);
        end else begin
          exp_v = q.pop_front();
          if ({bus.out_value, bus.out_id} !== exp_v) begin
            errors++;
            $display("FAIL rand_out[%0d] got %03h/%02h want %03h/%02h",
                     got, bus.out_value, bus.out_id, exp_v[19:8], exp_v[7:0]);
          end
        end
        got++;
      end
      tick();
    end
    $display("random sent=%0d got=%0d", sent, got);
    checks++;
    if (got != sent || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", got, sent);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL rand_hold got %0d violations want 0", hold_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_busy_idle got %0b want 0", busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
